// File: rtl/mem_req_arb_if.sv
// Shared request/response memory bus between the arbiter (master) and the
// memory-side slave. Requests use an addr_ok handshake, responses data_ok.
interface mem_req_arb_if;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_req_arb.sv
// Merges the core's fetch and data request streams onto one shared memory
// bus, one transaction in flight, data ahead of fetch. Holds the core via
// stall while any of its requests is outstanding and counts stall cycles.
module mem_req_arb #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_req,
    input  logic [31:0]      inst_addr,
    output logic [31:0]      inst_rdata,
    output logic             inst_valid,
    input  logic             data_req,
    input  logic [3:0]       data_wen,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic [31:0]      data_rdata,
    output logic             data_valid,
    output logic             stall,
    mem_req_arb_if.master    bus,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        DWAIT = 3'd2,
        IREQ  = 3'd3,
        IWAIT = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t state;

    // Byte enables to {size, low address bits}; unsupported masks act as a word.
    function automatic logic [3:0] wen_decode(input logic [3:0] wen);
        logic [3:0] r;
        // NOTE: default assigned before the case so every path writes r; no latch.
        r = {2'd2, 2'b00};
        case (wen)
            4'b1111: r = {2'd2, 2'b00};
            4'b0011: r = {2'd1, 2'b00};
            4'b1100: r = {2'd1, 2'b10};
            4'b0001: r = {2'd0, 2'b00};
            4'b0010: r = {2'd0, 2'b01};
            4'b0100: r = {2'd0, 2'b10};
            4'b1000: r = {2'd0, 2'b11};
            default: r = {2'd2, 2'b00};
        endcase
        return r;
    endfunction

    logic [3:0] wr_code;
    assign wr_code = wen_decode(data_wen);

    // Core hold: a request is pending until its own valid pulse is seen.
    assign stall = (inst_req & ~inst_valid) | (data_req & ~data_valid);

    // Transaction FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_size  <= 2'd0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
            inst_valid    <= 1'b0;
            data_valid    <= 1'b0;
            inst_rdata    <= 32'd0;
            data_rdata    <= 32'd0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            inst_valid <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_wdata <= data_wdata;
                        if (data_wen == 4'b0000) begin
                            bus.bus_wr   <= 1'b0;
                            bus.bus_size <= 2'd2;
                            bus.bus_addr <= data_addr & 32'hFFFF_FFFC;
                        end else begin
                            bus.bus_wr   <= 1'b1;
                            bus.bus_size <= wr_code[3:2];
                            bus.bus_addr <= (data_addr & 32'hFFFF_FFFC) | {30'd0, wr_code[1:0]};
                        end
                        state <= DREQ;
                    end else if (inst_req) begin
                        bus.bus_req  <= 1'b1;
                        bus.bus_wr   <= 1'b0;
                        bus.bus_size <= 2'd2;
                        bus.bus_addr <= inst_addr & 32'hFFFF_FFFC;
                        state        <= IREQ;
                    end
                end
                DREQ: begin
                    if (bus.bus_addr_ok) begin
                        bus.bus_req <= 1'b0;
                        state       <= DWAIT;
                    end
                end
                IREQ: begin
                    if (bus.bus_addr_ok) begin
                        bus.bus_req <= 1'b0;
                        state       <= IWAIT;
                    end
                end
                DWAIT: begin
                    if (bus.bus_data_ok) begin
                        data_rdata <= bus.bus_rdata;
                        data_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                IWAIT: begin
                    if (bus.bus_data_ok) begin
                        inst_rdata <= bus.bus_rdata;
                        inst_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of cycles the core spends stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_req_arb.sv
// Directed bench for mem_req_arb: a behavioural bus slave with programmable
// addr_ok / data_ok delays, core-side request sequences, and fixed expected
// values for each transaction.
module tb_mem_req_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_valid;
    logic        stall;
    logic [3:0]  stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mem_req_arb_if bus ();

    mem_req_arb #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_valid (inst_valid),
        .data_req   (data_req),
        .data_wen   (data_wen),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_valid (data_valid),
        .stall      (stall),
        .bus        (bus.master),
        .stall_cnt  (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave read data: fixed words for the addresses the plan names.
    function automatic logic [31:0] rd_for(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h2408_0001;
            32'h8000_0010: return 32'h1234_5678;
            default:       return a ^ 32'hFFFF_0000;
        endcase
    endfunction

    // ---------------- bus slave model ----------------
    int          addr_dly = 0;
    int          data_dly = 1;
    int          sst = 0, held = 0, dcnt = 0;
    bit          seen = 1'b0;
    int          txn_cnt = 0, stab_err = 0;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_size;
    logic        snap_wr;
    logic [31:0] acc_addr[$];

    initial begin
        bus.bus_addr_ok = 1'b0;
        bus.bus_data_ok = 1'b0;
        bus.bus_rdata   = 32'd0;
        forever begin
            tick();
            bus.bus_addr_ok = 1'b0;
            bus.bus_data_ok = 1'b0;
            if (rst) begin
                sst = 0; held = 0; seen = 1'b0;
            end else if (sst == 0) begin
                if (bus.bus_req) begin
                    if (!seen) begin
                        seen       = 1'b1;
                        snap_addr  = bus.bus_addr;
                        snap_wdata = bus.bus_wdata;
                        snap_size  = bus.bus_size;
                        snap_wr    = bus.bus_wr;
                    end else if (bus.bus_addr !== snap_addr || bus.bus_size !== snap_size ||
                                 bus.bus_wr !== snap_wr || bus.bus_wdata !== snap_wdata) begin
                        stab_err++;
                    end
                    if (held >= addr_dly) begin
                        bus.bus_addr_ok = 1'b1;
                        txn_cnt++;
                        acc_addr.push_back(snap_addr);
                        sst = 1; dcnt = 1; held = 0; seen = 1'b0;
                    end else begin
                        held++;
                    end
                end
            end else begin
                if (dcnt >= data_dly) begin
                    bus.bus_data_ok = 1'b1;
                    bus.bus_rdata   = rd_for(snap_addr);
                    sst = 0;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    // Ticks until the chosen valid pulses (0 on timeout); also counts
    // pre-pulse cycles where stall was unexpectedly low.
    task automatic wait_valid(input bit is_data, output int n, output int stall_lo);
        n = 0;
        stall_lo = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (is_data ? data_valid : inst_valid) begin
                n = i;
                return;
            end
            if (!stall) stall_lo++;
        end
    endtask

    logic [3:0]  st_wen  [5] = '{4'b1000, 4'b1100, 4'b0011, 4'b0001, 4'b0101};
    logic [31:0] st_addr [5] = '{32'h8000_1002, 32'h8000_1000, 32'h8000_1000, 32'h8000_1000, 32'h8000_1003};
    logic [1:0]  st_size [5] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2};
    logic [31:0] st_baddr[5] = '{32'h8000_1003, 32'h8000_1002, 32'h8000_1000, 32'h8000_1000, 32'h8000_1000};

    initial begin
        int n, lo, t0;
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wen = 4'd0; data_addr = 32'd0; data_wdata = 32'd0;
        tick();
        tick();

        // Reset values
        check("rst_state", 32'(dut.state), 32'd0);
        check("rst_bus_req", bus.bus_req, 1'b0);
        check("rst_bus_addr", bus.bus_addr, 32'd0);
        check("rst_bus_size", bus.bus_size, 2'd0);
        check("rst_valids", {inst_valid, data_valid}, 2'b00);
        check("rst_rdata", inst_rdata | data_rdata, 32'd0);
        check("rst_stall_cnt", stall_cnt, 4'd0);
        rst = 1'b0;
        tick();

        // Fetch, addr_ok immediate, data_ok two cycles after bus_req rises
        addr_dly = 0; data_dly = 2;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1 check("fetch_stall_pre", stall, 1'b1);
        wait_valid(1'b0, n, lo);
        check("fetch_latency", n, 4);
        check("fetch_stall_before", lo, 0);
        check("fetch_rdata", inst_rdata, 32'h2408_0001);
        check("fetch_stall_at_valid", stall, 1'b0);
        check("fetch_no_dvalid", data_valid, 1'b0);
        check("fetch_bus_addr", snap_addr, 32'hBFC0_0000);
        check("fetch_bus_rd", {snap_wr, snap_size}, 3'b010);
        check("fetch_stall_cnt", stall_cnt, 4'd4);
        inst_req = 1'b0;
        tick();
        check("fetch_pulse_one", inst_valid, 1'b0);

        // Stores: size / address derived from byte enables, minimum latency
        data_dly = 1;
        for (int i = 0; i < 5; i++) begin
            data_req = 1'b1; data_wen = st_wen[i]; data_addr = st_addr[i];
            data_wdata = 32'hA0B0_C0D0 + 32'(i);
            wait_valid(1'b1, n, lo);
            check($sformatf("st%0d_latency", i), n, 3);
            check($sformatf("st%0d_wr", i), snap_wr, 1'b1);
            check($sformatf("st%0d_size", i), snap_size, st_size[i]);
            check($sformatf("st%0d_addr", i), snap_addr, st_baddr[i]);
            check($sformatf("st%0d_wdata", i), snap_wdata, 32'hA0B0_C0D0 + 32'(i));
            check($sformatf("st%0d_rdata", i), data_rdata, st_baddr[i] ^ 32'hFFFF_0000);
            check($sformatf("st%0d_stall_at_valid", i), stall, 1'b0);
            data_req = 1'b0; data_wen = 4'd0;
            tick();
            check($sformatf("st%0d_pulse_one", i), data_valid, 1'b0);
        end

        // Simultaneous fetch and data read: data first, fetch afterwards
        t0 = txn_cnt;
        acc_addr.delete();
        inst_req = 1'b1; inst_addr = 32'h8000_0100;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0010;
        wait_valid(1'b1, n, lo);
        check("sim_data_latency", n, 3);
        check("sim_data_rdata", data_rdata, 32'h1234_5678);
        check("sim_stall_at_dvalid", stall, 1'b1);
        check("sim_no_ivalid", inst_valid, 1'b0);
        data_req = 1'b0;
        wait_valid(1'b0, n, lo);
        check("sim_inst_latency", n, 4);
        check("sim_inst_stall_before", lo, 0);
        check("sim_inst_rdata", inst_rdata, 32'h7FFF_0100);
        check("sim_stall_at_ivalid", stall, 1'b0);
        check("sim_txn_count", txn_cnt - t0, 2);
        check("sim_first_addr", (acc_addr.size() > 0) ? acc_addr[0] : 32'hDEAD_BEEF, 32'h8000_0010);
        inst_req = 1'b0;
        tick();

        // Reset while waiting for data_ok
        data_dly = 10;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0040;
        tick(); tick(); tick();
        check("midrst_in_dwait", 32'(dut.state), 32'd2);
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(dut.state), 32'd0);
        check("midrst_bus_req", bus.bus_req, 1'b0);
        check("midrst_valids", {inst_valid, data_valid}, 2'b00);
        check("midrst_stall_cnt", stall_cnt, 4'd0);
        data_req = 1'b0;
        rst = 1'b0;
        tick();

        // Slave back-pressure: addr_ok withheld for 5 cycles of bus_req
        t0 = txn_cnt; stab_err = 0;
        addr_dly = 5; data_dly = 1;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0020;
        wait_valid(1'b1, n, lo);
        check("bp_latency", n, 8);
        check("bp_stable", stab_err, 0);
        check("bp_one_txn", txn_cnt - t0, 1);
        check("bp_addr", snap_addr, 32'h8000_0020);
        check("bp_rdata", data_rdata, 32'h7FFF_0020);
        check("bp_stall_cnt", stall_cnt, 4'd8);
        data_req = 1'b0;
        tick(); tick();
        check("bp_no_reissue", txn_cnt - t0, 1);

        // Counter saturation: 20 stalled cycles into a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        addr_dly = 17;
        data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h8000_0030;
        wait_valid(1'b1, n, lo);
        check("sat_latency", n, 20);
        check("sat_stall_cnt", stall_cnt, 4'd15);
        data_req = 1'b0;
        tick(); tick(); tick();
        check("sat_hold", stall_cnt, 4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
